// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART timing constants, transmitter FSM encoding, parity helper.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package uart_tx_pkg;

  localparam int unsigned SYS_FRE    = 32'd24_000_000;
  localparam int unsigned BPS        = 32'd115200;
  // 24e6/115200 = 208.33 truncates to 208, so 13 clocks per 1/16 bit.
  localparam int unsigned DIV_CLK    = (SYS_FRE / BPS) >> 4;
  localparam int unsigned BIT_CYC    = 16 * DIV_CLK;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned FRAME_CYC  = FRAME_BITS * BIT_CYC;
  localparam int unsigned SUB_W      = $clog2(DIV_CLK);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Even parity bit: data plus this bit holds an even number of ones.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side parallel write bus and status flags of the UART transmitter.
// Ports: wrn (active-low write strobe), dat_i (byte), thr_empty, tx_busy, tx_done, wr_ovr.
// Backpressure: host must watch thr_empty; a write into a full holding register pulses wr_ovr.
interface uart_tx_if;
  logic       wrn;
  logic [7:0] dat_i;
  logic       thr_empty;
  logic       tx_busy;
  logic       tx_done;
  logic       wr_ovr;

  modport master (output wrn, dat_i, input thr_empty, tx_busy, tx_done, wr_ovr);
  modport slave  (input wrn, dat_i, output thr_empty, tx_busy, tx_done, wr_ovr);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: DIV_CLK x 16 tick generator; bit_end marks the last clock of each bit.
// Ports: clk24m, rst_n, restart (sync clear, holds counters at 0), bit_end (1-cycle pulse).
// Latency: first bit_end exactly BIT_CYC clocks after restart drops; no backpressure.
module uart_baud_gen
  import uart_tx_pkg::*;
(
  input  logic clk24m,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  logic [SUB_W-1:0] sub_cnt;
  logic [3:0]       tick_cnt;
  logic             sub_wrap;

  assign sub_wrap = (sub_cnt == SUB_W'(DIV_CLK - 1));
  assign bit_end  = sub_wrap && (tick_cnt == 4'd15);

  always_ff @(posedge clk24m or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt  <= '0;
      tick_cnt <= '0;
    end else if (restart) begin
      sub_cnt  <= '0;
      tick_cnt <= '0;
    end else if (sub_wrap) begin
      sub_cnt  <= '0;
      tick_cnt <= tick_cnt + 4'd1;  // 4-bit wrap ends the bit
    end else begin
      sub_cnt  <= sub_cnt + SUB_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8E1 UART transmitter with one-deep holding register ahead of the shift register.
// Ports: clk24m, rst_n, host (uart_tx_if.slave), tx_dat (serial line, idle high).
// Latency: tx_dat falls 2 clocks after write detect; drops writes with wr_ovr when holding reg is full.
module uart_tx
  import uart_tx_pkg::*;
(
  input  logic     clk24m,
  input  logic     rst_n,
  uart_tx_if.slave host,
  output logic     tx_dat
);

  tx_state_e  state, state_nxt;
  logic       wrn_q, wr_acc, wr_take;
  logic       load_tsr, shift_en, restart, bit_end, tx_done_c;
  logic [7:0] thr, tsr;
  logic       thr_empty, par, wr_ovr_q;
  logic [2:0] bit_cnt;

  uart_baud_gen u_baud (
    .clk24m  (clk24m),
    .rst_n   (rst_n),
    .restart (restart),
    .bit_end (bit_end)
  );

  // Falling edge of wrn; a held-low strobe yields a single write.
  assign wr_acc  = ~host.wrn & wrn_q;
  // A transfer in the same cycle frees the holding register, so the write still lands.
  assign wr_take = wr_acc && (thr_empty || load_tsr);

  always_ff @(posedge clk24m or negedge rst_n) begin
    if (!rst_n) begin
      wrn_q     <= 1'b1;
      thr       <= '0;
      thr_empty <= 1'b1;
      wr_ovr_q  <= 1'b0;
    end else begin
      wrn_q    <= host.wrn;
      wr_ovr_q <= wr_acc && !wr_take;
      if (wr_take) begin
        thr       <= host.dat_i;
        thr_empty <= 1'b0;
      end else if (load_tsr) begin
        thr_empty <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk24m or negedge rst_n) begin
    if (!rst_n) begin
      tsr     <= '0;
      par     <= 1'b0;
      bit_cnt <= '0;
    end else if (load_tsr) begin
      tsr     <= thr;
      par     <= even_par(thr);
      bit_cnt <= '0;
    end else if (shift_en) begin
      tsr     <= {1'b0, tsr[7:1]};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk24m or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_tsr  = 1'b0;
    shift_en  = 1'b0;
    tx_done_c = 1'b0;
    restart   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Counters held at zero so the start bit gets a full bit time.
        restart = 1'b1;
        if (!thr_empty) begin
          load_tsr  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START:  if (bit_end) state_nxt = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
      end
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          tx_done_c = 1'b1;
          // Chain straight into the next start bit; the baud counters wrap to 0 here.
          if (!thr_empty) begin
            load_tsr  = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decoded from registers only, so an async reset forces the line high at once.
  always_comb begin
    tx_dat = 1'b1;
    case (state)
      ST_START:  tx_dat = 1'b0;
      ST_DATA:   tx_dat = tsr[0];
      ST_PARITY: tx_dat = par;
      default:   tx_dat = 1'b1;
    endcase
  end

  assign host.thr_empty = thr_empty;
  assign host.tx_busy   = (state != ST_IDLE);
  assign host.tx_done   = tx_done_c;
  assign host.wr_ovr    = wr_ovr_q;

endmodule
